// File: rtl/cpu15_pkg.sv
// Shared definitions for the 15-bit CPU.
// Opcodes, sequencer states and instruction field positions.
package cpu15_pkg;

  localparam int W_INSTR = 15;
  localparam int W_ADDR  = 8;
  localparam int OP_MSB  = 14;
  localparam int OP_LSB  = 11;
  localparam int AD_MSB  = 7;
  localparam int AD_LSB  = 0;

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LDL = 4'b0010;
  localparam logic [3:0] OP_LDH = 4'b0011;
  localparam logic [3:0] OP_ST  = 4'b0100;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_JE  = 4'b1011;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_HLT = 4'b1111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT
  } state_t;

  function automatic logic [3:0] opc_of(
    input logic [W_INSTR-1:0] w
  );
    return w[OP_MSB:OP_LSB];
  endfunction

  function automatic logic [W_ADDR-1:0] adr_of(
    input logic [W_INSTR-1:0] w
  );
    return w[AD_MSB:AD_LSB];
  endfunction

endpackage

// File: rtl/cpu15_pc_reg.sv
// Program counter register.
// Reset-load, then absolute load, then increment.
module cpu15_pc_reg #(
  parameter logic [7:0] RESET_VAL = 8'h00
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_load,
  input  logic [7:0] i_addr,
  input  logic       i_inc,
  output logic [7:0] o_pc
);

  logic [7:0] r_pc;

  // load beats increment; increment wraps mod 256
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)
      r_pc <= RESET_VAL;
    else if (i_load)
      r_pc <= i_addr;
    else if (i_inc)
      r_pc <= r_pc + 8'd1;
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/sequencer.sv
// Four-phase instruction sequencer.
// FETCH/DECODE/EXEC/WB strobes, PC update, sticky halt.
module sequencer
  import cpu15_pkg::*;
#(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic                 RUN,
  input  logic [W_INSTR-1:0]   INSTR,
  input  logic                 CMP_FLAG,
  output logic [W_ADDR-1:0]    P_COUNT,
  output logic                 FT_EN,
  output logic                 DC_EN,
  output logic                 EX_EN,
  output logic                 WB_EN,
  output logic [W_INSTR-1:0]   IR,
  output logic                 HALTED
);

  state_t               r_state;
  logic [W_INSTR-1:0]   r_ir;
  logic                 r_flag;
  logic                 r_ft;
  logic                 r_dc;
  logic                 r_ex;
  logic                 r_wb;
  logic                 r_halted;

  logic [3:0]           w_op;
  logic [W_ADDR-1:0]    w_adr;
  logic                 w_load;
  logic                 w_inc;

  assign w_op  = opc_of(r_ir);
  assign w_adr = adr_of(r_ir);

  // PC control, only active in the write-back phase
  always_comb begin
    w_load = 1'b0;
    w_inc  = 1'b0;
    if (r_state == S_WB) begin
      unique case (1'b1)
        (w_op == OP_JMP):           w_load = 1'b1;
        (w_op == OP_JE && r_flag):  w_load = 1'b1;
        (w_op == OP_HLT):           w_inc  = 1'b0;
        default:                    w_inc  = 1'b1;
      endcase
    end
  end

  cpu15_pc_reg #(
    .RESET_VAL (RESET_PC)
  ) u_pc (
    .i_clk   (CLK),
    .i_rst_n (RESET_N),
    .i_load  (w_load),
    .i_addr  (w_adr),
    .i_inc   (w_inc),
    .o_pc    (P_COUNT)
  );

  // phase FSM; strobes registered alongside the next state
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_state  <= S_IDLE;
      r_ir     <= '0;
      r_flag   <= 1'b0;
      r_ft     <= 1'b0;
      r_dc     <= 1'b0;
      r_ex     <= 1'b0;
      r_wb     <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (RUN) begin
            r_state <= S_FETCH;
            r_ft    <= 1'b1;
          end
        end
        S_FETCH: begin
          r_state <= S_DECODE;
          r_ft    <= 1'b0;
          r_dc    <= 1'b1;
        end
        S_DECODE: begin
          r_ir    <= INSTR;
          r_state <= S_EXEC;
          r_dc    <= 1'b0;
          r_ex    <= 1'b1;
        end
        S_EXEC: begin
          if (w_op == OP_CMP)
            r_flag <= CMP_FLAG;
          r_state <= S_WB;
          r_ex    <= 1'b0;
          r_wb    <= 1'b1;
        end
        S_WB: begin
          r_wb <= 1'b0;
          if (w_op == OP_HLT) begin
            r_state  <= S_HALT;
            r_halted <= 1'b1;
          end else if (RUN) begin
            r_state <= S_FETCH;
            r_ft    <= 1'b1;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_HALT: begin
          r_state <= S_HALT;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign FT_EN  = r_ft;
  assign DC_EN  = r_dc;
  assign EX_EN  = r_ex;
  assign WB_EN  = r_wb;
  assign IR     = r_ir;
  assign HALTED = r_halted;

endmodule

// File: doc/sequencer.md
SEQUENCER -- requirements
Module: sequencer

Interface
REQ-001 Parameter: RESET_PC, default 8'h00, program-counter value loaded on reset.
REQ-002 CLK  input  1  single system clock; all state updates on its rising edge.
REQ-003 RESET_N  input  1  synchronous, active-low reset.
REQ-004 RUN  input  1  level; 1 permits instruction sequencing, 0 parks the sequencer at the next fetch boundary.
REQ-005 INSTR  input  15  instruction word from the fetch stage (opcode [14:11], address [7:0]).
REQ-006 CMP_FLAG  input  1  equality flag from execute stage, valid during EXEC.
REQ-007 P_COUNT  output  8  current program counter, drives fetch-stage address.
REQ-008 FT_EN, DC_EN, EX_EN, WB_EN  output  1 each  one-cycle phase strobes for fetch/decode/execute/write-back stages.
REQ-009 IR  output  15  latched instruction register.
REQ-010 HALTED  output  1  high while in HALT state.

Function
REQ-011 States: IDLE, FETCH, DECODE, EXEC, WB, HALT; exactly one phase strobe high in FETCH/DECODE/EXEC/WB, none in IDLE/HALT.
REQ-012 IDLE -> FETCH when RUN=1; IDLE holds when RUN=0.
REQ-013 FETCH -> DECODE unconditionally; FT_EN=1 in FETCH; P_COUNT stable throughout FETCH.
REQ-014 DECODE: IR <= INSTR at end of DECODE cycle (fetch output registered by FT_EN edge is valid here); DECODE -> EXEC.
REQ-015 EXEC: CMP_FLAG sampled into internal flag at end of EXEC only if IR opcode = cmp (4'b1010); otherwise flag retained; EXEC -> WB.
REQ-016 WB PC update: jmp (4'b1100) -> P_COUNT <= IR[7:0]; je (4'b1011) with flag=1 -> IR[7:0]; je with flag=0 -> P_COUNT+1; hlt (4'b1111) -> P_COUNT unchanged; all other opcodes -> P_COUNT+1.
REQ-017 Increment is modulo 256: 8'hFF + 1 -> 8'h00, no flag, no halt.
REQ-018 WB -> HALT if opcode = hlt; else WB -> FETCH if RUN=1, WB -> IDLE if RUN=0.
REQ-019 RUN deasserted mid-instruction: current instruction completes through WB including PC update; no partial abort.
REQ-020 HALT is sticky; only RESET_N=0 leaves it; RUN ignored in HALT.
REQ-021 Instruction latency: fixed 4 cycles FETCH->WB; back-to-back instructions issue every 4 cycles with RUN=1.
REQ-022 Undefined opcodes treated as non-branch: PC+1, no halt.

Reset
REQ-023 RESET_N=0 at a rising CLK edge: state <= IDLE, P_COUNT <= RESET_PC, IR <= 0, flag <= 0, all strobes 0, HALTED 0.
REQ-024 Reset applies in any state including mid-instruction and HALT; reset wins over all simultaneous events.
REQ-025 Outputs are registered or decoded purely from state; no combinational path from inputs to strobes.

Structure
REQ-026 Shared package cpu15_pkg holds the 4-bit opcode constants (add, ldl, ldh, cmp, je, jmp, st, hlt, nop), the state enumeration and field-position constants of the 15-bit word.
REQ-027 One sub-module: cpu15_pc_reg (8-bit register with synchronous reset-load, load-address and increment controls, load priority over increment).

Verification
REQ-028 Reset then RUN=1, INSTR=nop stream -> P_COUNT 00,01,02 on successive WB, strobes FT,DC,EX,WB repeat every 4 cycles.
REQ-029 INSTR=jmp 8'h08 (15'b110000000001000) at P_COUNT 8'h13 -> next FETCH shows P_COUNT=8'h08.
REQ-030 cmp with CMP_FLAG=1 then je 8'h0E -> P_COUNT=8'h0E; same with CMP_FLAG=0 -> P_COUNT+1.
REQ-031 hlt (15'b111100000000000) -> HALTED=1, P_COUNT frozen, no strobes for 20 cycles despite RUN=1; RESET_N=0 -> IDLE, P_COUNT=RESET_PC.
REQ-032 P_COUNT=8'hFF, nop -> P_COUNT=8'h00; RUN dropped during DECODE -> WB completes, state IDLE, P_COUNT incremented once.
REQ-033 RESET_N=0 asserted during EXEC -> next cycle IDLE, IR=0, no WB strobe, P_COUNT=RESET_PC.
